// File: rtl/alert_arbiter.sv
// Round-robin arbiter sharing one alarm annunciator among NUM_SRC sticky alert units.
// Optional escalation timer is enabled by defining ALERT_ARBITER_ESCALATE_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no alarm presented; grant the next eligible source if any
// PRESENT | alarm_valid high, alarm_id fixed until alarm_ack
// CLEAR   | one-cycle src_clr pulse to the granted source, advance ptr
// HOLDOFF | dead cycle so the cleared source's q can fall
module alert_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TIMEOUT = 16,
    localparam int IDW = $clog2(NUM_SRC),
    localparam int CW  = $clog2(NUM_SRC + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] alert_req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               alarm_ack,
    output logic               alarm_valid,
    output logic [IDW-1:0]     alarm_id,
    output logic [NUM_SRC-1:0] src_clr,
    output logic               busy,
    output logic [CW-1:0]      pending_cnt,
    output logic               escalate
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] CLEAR   = 2'd2;
    localparam logic [1:0] HOLDOFF = 2'd3;

    localparam logic [IDW:0]   NSRC    = (IDW + 1)'(NUM_SRC);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_SRC - 1);

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("alert_arbiter: NUM_SRC out of range 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("alert_arbiter: TIMEOUT out of range 1..255");
    end

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       ptr_nxt;
    logic [IDW-1:0]       gnt_id;
    logic [IDW-1:0]       win_id;
    logic [IDW-1:0]       win_off;
    logic [IDW:0]         win_sum;
    logic [NUM_SRC-1:0]   eligible;
    logic [2*NUM_SRC-1:0] rot;
    logic [NUM_SRC-1:0]   clr_vec;

    assign eligible = alert_req & ~mask;

    // Doubling the vector lets a plain right shift implement the wrap-around scan.
    always_comb begin
        rot     = {eligible, eligible} >> ptr;
        win_off = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (rot[j]) begin
                win_off = IDW'(j);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, win_off};
        if (win_sum >= NSRC) begin
            win_id = IDW'(win_sum - NSRC);
        end else begin
            win_id = win_sum[IDW-1:0];
        end
    end

    always_comb begin
        ptr_nxt = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
        clr_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_vec[i] = (gnt_id == IDW'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|eligible) state_nxt = PRESENT;
            PRESENT: if (alarm_ack) state_nxt = CLEAR;
            CLEAR:   state_nxt = HOLDOFF;
            HOLDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt_id      <= '0;
            alarm_valid <= 1'b0;
            alarm_id    <= '0;
            src_clr     <= '0;
            busy        <= 1'b0;
            pending_cnt <= '0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            pending_cnt <= CW'($countones(eligible));
            src_clr     <= '0;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        gnt_id      <= win_id;
                        alarm_valid <= 1'b1;
                        alarm_id    <= win_id;
                    end
                end
                PRESENT: begin
                    // Grant is held regardless of mask/req changes; only ack ends it.
                    if (alarm_ack) begin
                        alarm_valid <= 1'b0;
                        alarm_id    <= '0;
                        src_clr     <= clr_vec;
                    end
                end
                CLEAR: begin
                    ptr <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef ALERT_ARBITER_ESCALATE_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;

    assign timer_inc = (timer == TMAX) ? TMAX : timer + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer    <= '0;
            escalate <= 1'b0;
        end else if (state == PRESENT && !alarm_ack) begin
            timer    <= timer_inc;
            escalate <= (timer_inc == TMAX);
        end else begin
            timer    <= '0;
            escalate <= 1'b0;
        end
    end
`else
    assign escalate = 1'b0;
`endif

endmodule

// File: tb/tb_alert_arbiter.sv
// Directed bench for alert_arbiter: reset, round robin, masking, clear pulse,
// async reset mid-grant and (when ALERT_ARBITER_ESCALATE_EN is defined) escalation.
module tb_alert_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] alert_req;
    logic [3:0] mask;
    logic       alarm_ack;
    logic       alarm_valid;
    logic [1:0] alarm_id;
    logic [3:0] src_clr;
    logic       busy;
    logic [2:0] pending_cnt;
    logic       escalate;

    int checks   = 0;
    int failures = 0;

`ifdef ALERT_ARBITER_ESCALATE_EN
    localparam logic ESC_EXP = 1'b1;
`else
    localparam logic ESC_EXP = 1'b0;
`endif

    alert_arbiter #(.NUM_SRC(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .alert_req   (alert_req),
        .mask        (mask),
        .alarm_ack   (alarm_ack),
        .alarm_valid (alarm_valid),
        .alarm_id    (alarm_id),
        .src_clr     (src_clr),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .escalate    (escalate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] rr_ids [5];
        rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst       = 1'b0;
        alert_req = '0;
        mask      = '0;
        alarm_ack = 1'b0;
        #3;
        chk("rst_valid", alarm_valid, 0);
        chk("rst_id", alarm_id, 0);
        chk("rst_clr", src_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending_cnt, 0);
        chk("rst_esc", escalate, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // ack while idle with nothing pending is ignored
        alarm_ack = 1'b1;
        step();
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_valid", alarm_valid, 0);
        chk("idle_ack_clr", src_clr, 0);
        step();
        chk("idle_ack_clr2", src_clr, 0);
        alarm_ack = 1'b0;

        // round robin with all four requesting
        alert_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_valid", alarm_valid, 1);
            chk("rr_id", alarm_id, rr_ids[k]);
            chk("rr_pend", pending_cnt, 4);
            alarm_ack = 1'b1;
            step();
            chk("rr_clr", src_clr, 32'(4'b0001 << rr_ids[k]));
            chk("rr_clr_valid", alarm_valid, 0);
            alarm_ack = 1'b0;
            step();
            chk("rr_hold_clr", src_clr, 0);
            chk("rr_hold_busy", busy, 1);
            step();
        end

        // single request, full handshake timing
        alert_req = 4'b0100;
        step();
        chk("s_valid", alarm_valid, 1);
        chk("s_id", alarm_id, 2);
        chk("s_busy", busy, 1);
        chk("s_pend", pending_cnt, 1);
        alarm_ack = 1'b1;
        step();
        chk("s_clr", src_clr, 4'b0100);
        chk("s_valid0", alarm_valid, 0);
        chk("s_id0", alarm_id, 0);
        chk("s_busy_clr", busy, 1);
        alarm_ack = 1'b0;
        alert_req = 4'b0000;
        step();
        chk("s_clr_off", src_clr, 0);
        chk("s_busy_hold", busy, 1);
        step();
        chk("s_busy_idle", busy, 0);
        chk("s_valid_idle", alarm_valid, 0);

        // fresh pointer, then masking
        rst = 1'b0;
        step();
        rst = 1'b1;
        alert_req = 4'b1010;
        mask      = 4'b0010;
        step();
        chk("m_valid", alarm_valid, 1);
        chk("m_id", alarm_id, 3);
        chk("m_pend", pending_cnt, 1);
        mask = 4'b1010;
        step();
        step();
        chk("m_hold_valid", alarm_valid, 1);
        chk("m_hold_id", alarm_id, 3);
        chk("m_hold_pend", pending_cnt, 0);
        alarm_ack = 1'b1;
        step();
        chk("m_clr", src_clr, 4'b1000);
        alarm_ack = 1'b0;
        alert_req = 4'b0010;
        mask      = 4'b0010;
        step();
        step();
        step();
        chk("m_none_busy", busy, 0);
        chk("m_none_valid", alarm_valid, 0);
        mask = 4'b0000;
        step();
        chk("m_wrap_valid", alarm_valid, 1);
        chk("m_wrap_id", alarm_id, 1);

        // async reset while presenting id 1
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", alarm_valid, 0);
        chk("ar_id", alarm_id, 0);
        chk("ar_busy", busy, 0);
        chk("ar_clr", src_clr, 0);
        chk("ar_pend", pending_cnt, 0);
        chk("ar_esc", escalate, 0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("ar_regrant_valid", alarm_valid, 1);
        chk("ar_regrant_id", alarm_id, 1);
        chk("ar_regrant_clr", src_clr, 0);

        // withhold ack: escalation boundary at 16 cycles
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 15) begin
                chk("esc_pre", escalate, 0);
                chk("esc_pre_valid", alarm_valid, 1);
            end
        end
        chk("esc_at", escalate, 32'(ESC_EXP));
        chk("esc_at_id", alarm_id, 1);
        step();
        chk("esc_stay", escalate, 32'(ESC_EXP));
        alarm_ack = 1'b1;
        step();
        chk("esc_ack_esc", escalate, 0);
        chk("esc_ack_valid", alarm_valid, 0);
        chk("esc_ack_clr", src_clr, 4'b0010);
        alarm_ack = 1'b0;
        alert_req = 4'b0000;
        step();
        step();
        chk("end_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
